// File: rtl/lsq_ooo_fwd_if.sv
// ============================================================================
// Module : lsq_ooo_fwd_if
// Dispatch, CDB, store-commit and load-offer signals of the load/store queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface lsq_ooo_fwd_if #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic               enq_valid;
  logic               enq_ready;
  logic               enq_load;
  logic [TAG_W-1:0]   enq_rob_tag;
  logic [TAG_W-1:0]   enq_q_store;
  logic [XLEN-1:0]    enq_store_data;
  logic               cdb_valid;
  logic [TAG_W-1:0]   cdb_tag;
  logic               cdb_is_addr;
  logic [XLEN-1:0]    cdb_result;
  logic               st_commit;
  logic               st_mem_valid;
  logic [XLEN-1:0]    st_mem_addr;
  logic [XLEN-1:0]    st_mem_data;
  logic               ld_out_valid;
  logic               ld_out_ready;
  logic [TAG_W-1:0]   ld_out_tag;
  logic               ld_out_fwd;
  logic [XLEN-1:0]    ld_out_addr;
  logic [XLEN-1:0]    ld_out_data;
  logic [c_cnt_w-1:0] count;
  logic               empty;

  modport master (
    output enq_valid, enq_load, enq_rob_tag, enq_q_store, enq_store_data,
    output cdb_valid, cdb_tag, cdb_is_addr, cdb_result,
    output st_commit, ld_out_ready,
    input  enq_ready, st_mem_valid, st_mem_addr, st_mem_data,
    input  ld_out_valid, ld_out_tag, ld_out_fwd, ld_out_addr, ld_out_data,
    input  count, empty
  );

  modport slave (
    input  enq_valid, enq_load, enq_rob_tag, enq_q_store, enq_store_data,
    input  cdb_valid, cdb_tag, cdb_is_addr, cdb_result,
    input  st_commit, ld_out_ready,
    output enq_ready, st_mem_valid, st_mem_addr, st_mem_data,
    output ld_out_valid, ld_out_tag, ld_out_fwd, ld_out_addr, ld_out_data,
    output count, empty
  );
endinterface

`default_nettype wire

// File: rtl/lsq_ooo_fwd.sv
// ============================================================================
// Module : lsq_ooo_fwd
// Load/store queue: in-order enqueue, out-of-order load issue with forwarding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lsq_ooo_fwd #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  lsq_ooo_fwd_if.slave       bus
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic             r_valid      [DEPTH];
  logic             r_load       [DEPTH];
  logic [TAG_W-1:0] r_rob_tag    [DEPTH];
  logic [XLEN-1:0]  r_addr       [DEPTH];
  logic             r_addr_valid [DEPTH];
  logic [XLEN-1:0]  r_data       [DEPTH];
  logic [TAG_W-1:0] r_q_store    [DEPTH];
  logic             r_issued     [DEPTH];

  logic [c_ptr_w:0]   r_wptr;
  logic [c_ptr_w:0]   r_rptr;
  logic [c_cnt_w-1:0] r_count;

  logic [c_ptr_w-1:0] w_head;
  logic [c_ptr_w-1:0] w_widx;
  logic               w_enq_ready;
  logic               w_enq;
  logic               w_st_fire;
  logic               w_pop;
  logic               w_issue;
  logic               w_ld_found;
  logic [c_ptr_w-1:0] w_ld_idx;
  logic               w_ld_fwd;
  logic [XLEN-1:0]    w_ld_data;
  logic               w_cdb_data_hit;
  logic               w_cdb_addr_hit;

  assign w_head      = r_rptr[c_ptr_w-1:0];
  assign w_widx      = r_wptr[c_ptr_w-1:0];
  assign w_enq_ready = r_count < c_cnt_w'(DEPTH);
  assign w_enq       = bus.enq_valid && w_enq_ready;

  assign w_st_fire = r_valid[w_head] && !r_load[w_head] && r_addr_valid[w_head]
                     && (r_q_store[w_head] == '0) && bus.st_commit;
  assign w_pop     = w_st_fire || (r_valid[w_head] && r_load[w_head] && r_issued[w_head]);
  assign w_issue   = w_ld_found && bus.ld_out_ready;

  // A newly enqueued entry must see a broadcast on the same cycle it is written.
  assign w_cdb_addr_hit = bus.cdb_valid && bus.cdb_is_addr && (bus.cdb_tag == bus.enq_rob_tag);
  assign w_cdb_data_hit = bus.cdb_valid && !bus.cdb_is_addr && !bus.enq_load
                          && (bus.enq_q_store != '0) && (bus.cdb_tag == bus.enq_q_store);

  // Walk entries oldest-first; for each load, scan its older stores oldest-first so the
  // last address match seen is the youngest older store.
  always_comb begin
    logic [c_ptr_w-1:0] ia;
    logic [c_ptr_w-1:0] jk;
    logic               blocked;
    logic               m_found;
    logic               m_ready;
    logic [XLEN-1:0]    m_data;
    logic               elig;
    w_ld_found = 1'b0;
    w_ld_idx   = '0;
    w_ld_fwd   = 1'b0;
    w_ld_data  = '0;
    ia         = '0;
    jk         = '0;
    blocked    = 1'b0;
    m_found    = 1'b0;
    m_ready    = 1'b0;
    m_data     = '0;
    elig       = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      ia      = w_head + c_ptr_w'(a);
      blocked = 1'b0;
      m_found = 1'b0;
      m_ready = 1'b0;
      m_data  = '0;
      for (int k = 0; k < DEPTH; k++) begin
        jk = w_head + c_ptr_w'(k);
        if (k < a && r_valid[jk] && !r_load[jk]) begin
          if (!r_addr_valid[jk]) begin
            blocked = 1'b1;
          end else if (r_addr[jk] == r_addr[ia]) begin
            m_found = 1'b1;
            m_ready = (r_q_store[jk] == '0);
            m_data  = r_data[jk];
          end
        end
      end
      elig = r_valid[ia] && r_load[ia] && r_addr_valid[ia] && !r_issued[ia]
             && !blocked && !(m_found && !m_ready);
      if (elig && !w_ld_found) begin
        w_ld_found = 1'b1;
        w_ld_idx   = ia;
        w_ld_fwd   = m_found;
        w_ld_data  = m_found ? m_data : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]      <= 1'b0;
        r_addr_valid[i] <= 1'b0;
        r_issued[i]     <= 1'b0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && bus.cdb_valid) begin
          if (bus.cdb_is_addr && (r_rob_tag[i] == bus.cdb_tag)) begin
            r_addr[i]       <= bus.cdb_result;
            r_addr_valid[i] <= 1'b1;
          end
          if (!bus.cdb_is_addr && (r_q_store[i] != '0) && (r_q_store[i] == bus.cdb_tag)) begin
            r_data[i]    <= bus.cdb_result;
            r_q_store[i] <= '0;
          end
        end
      end
      if (w_issue) begin
        r_issued[w_ld_idx] <= 1'b1;
      end
      if (w_pop) begin
        r_valid[w_head] <= 1'b0;
        r_rptr          <= r_rptr + 1'b1;
      end
      // Enqueue only when not full, so the write slot never collides with the head pop.
      if (w_enq) begin
        r_valid[w_widx]      <= 1'b1;
        r_load[w_widx]       <= bus.enq_load;
        r_rob_tag[w_widx]    <= bus.enq_rob_tag;
        r_issued[w_widx]     <= 1'b0;
        r_addr[w_widx]       <= bus.cdb_result;
        r_addr_valid[w_widx] <= w_cdb_addr_hit;
        r_data[w_widx]       <= w_cdb_data_hit ? bus.cdb_result : bus.enq_store_data;
        r_q_store[w_widx]    <= (w_cdb_data_hit || bus.enq_load) ? '0 : bus.enq_q_store;
        r_wptr               <= r_wptr + 1'b1;
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.enq_ready    = w_enq_ready;
  assign bus.count        = r_count;
  assign bus.empty        = (r_count == '0);
  assign bus.st_mem_valid = w_st_fire;
  assign bus.st_mem_addr  = r_addr[w_head];
  assign bus.st_mem_data  = r_data[w_head];
  assign bus.ld_out_valid = w_ld_found;
  assign bus.ld_out_tag   = r_rob_tag[w_ld_idx];
  assign bus.ld_out_fwd   = w_ld_fwd;
  assign bus.ld_out_addr  = r_addr[w_ld_idx];
  assign bus.ld_out_data  = w_ld_data;

endmodule

`default_nettype wire
